dma_ahb_csr: RTL
================

DMA_AHB_CSR -- requirements
Module: dma_ahb_csr

Interface
REQ-001 SHALL have parameter P_VERSION, default 32'h2014_0429, read-only value of the VERSION register.
REQ-002 SHALL have ports HRESETn in 1, asynchronous active-low reset; HCLK in 1, the single clock, all logic on its rising edge.
REQ-003 SHALL have AHB slave inputs HSEL 1, HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HBURST 3, HWDATA 32, and HREADY 1 (bus-level ready).
REQ-004 SHALL have AHB slave outputs HRDATA 32, HRESP 2 and HREADYout 1.
REQ-005 SHALL have DMA-side outputs DMA_EN 1, DMA_GO 1, DMA_SRC 32, DMA_DST 32, DMA_BNUM 16 and DMA_BURST 5.
REQ-006 SHALL have DMA-side inputs DMA_BUSY 1 and DMA_DONE 1, driven by the DMA master engine.
REQ-007 SHALL have output IRQ 1, the level interrupt.

Function
REQ-008 SHALL decode HADDR[4:2] as the word register map: 0 CONTROL ([31] EN, [30] IE, [0] GO), 1 STATUS ([2] IP, [1] DONE, [0] BUSY, [3] ERR), 2 SRC, 3 DST, 4 BNUM[15:0], 5 BURST[4:0], 7 VERSION; all other offsets read 0 and ignore writes.
REQ-009 SHALL capture an access in its address phase when HSEL & HTRANS[1] & HREADY; IDLE and BUSY transfers are ignored.
REQ-010 SHALL perform a captured write at the end of the following cycle using HWDATA; byte lanes and HSIZE are ignored, so every write is a full word.
REQ-011 SHALL register HRDATA at the end of the read address phase, so it is valid in the data phase with zero wait states.
REQ-012 SHALL, on a read whose address phase coincides with a write data phase to the same offset, return the newly written value (bypass).
REQ-013 SHALL keep HREADYout 1 and HRESP 2'b00 (OKAY) at all times.
REQ-014 SHALL drive DMA_SRC, DMA_DST, DMA_BNUM, DMA_BURST and DMA_EN directly from their registers.
REQ-015 SHALL ignore writes to SRC, DST, BNUM and BURST while the GO FSM is not IDLE.
REQ-016 SHALL implement a GO FSM with the following states and transitions:
- IDLE -> ARMED on a CONTROL write with GO=1 and EN=1, when BNUM!=0 and BURST is in {1,4,8,16}.
- ARMED -> RELEASE when DMA_DONE==1.
- RELEASE -> IDLE when DMA_DONE==0.
- DMA_GO SHALL be 1 only in ARMED.
REQ-017 SHALL, in IDLE on a GO=1 write whose BNUM or BURST is illegal, stay IDLE and set ERR; ERR clears on a write-1 to STATUS[3].
REQ-018 SHALL treat a GO=1 write outside IDLE as a no-op; CONTROL.GO reads back as 1 exactly while the FSM is ARMED.
REQ-019 SHALL, on a write of EN=0 in any state, force the FSM to IDLE and DMA_GO to 0 on the next cycle.
REQ-020 SHALL have STATUS.BUSY and STATUS.DONE read DMA_BUSY and DMA_DONE directly, without synchronisation.

Reset
REQ-021 SHALL, while HRESETn==0, clear all registers, the FSM (IDLE), IP and ERR to 0, except VERSION.
REQ-022 SHALL hold outputs at: HRDATA 0, DMA_* 0, IRQ 0, HREADYout 1, HRESP 0.
REQ-023 SHALL, when reset asserts mid-transfer, drop DMA_GO immediately (asynchronously).

Configuration
REQ-024 SHALL, with DMA_AHB_CSR_IRQ_EN defined, set IP on the rising edge of DMA_DONE and drive IRQ = IP & IE.
REQ-025 SHALL clear IP on a write-1 to STATUS[2]; when a rising edge and the clear coincide, set wins.
REQ-026 SHALL, without DMA_AHB_CSR_IRQ_EN defined, tie IRQ to 0, make IE and IP read 0, and omit the edge detector.

Structure
REQ-027 SHALL take the register offsets, field bit positions and GO FSM state encodings from the shared package dma_ahb_pkg.
REQ-028 SHALL be one flat module with no sub-modules.

Verification
REQ-029 SHALL cover: writes SRC=0x1000, DST=0x2000, BNUM=64, BURST=4, then CONTROL=0x80000001 -> DMA_GO=1 from the next cycle; reading back each register returns the written value.
REQ-030 SHALL cover: while ARMED, pulse DMA_DONE high for 3 cycles and then low -> DMA_GO falls the cycle after DONE rises; the FSM returns to IDLE after DONE falls.
REQ-031 SHALL cover: BURST=5 then GO -> DMA_GO stays 0 and STATUS reads 0x8; a write of 0x8 to STATUS returns it to 0.
REQ-032 SHALL cover: back-to-back write SRC=0xA5A5A5A5 followed immediately by a read of SRC -> HRDATA=0xA5A5A5A5 with no wait state.
REQ-033 SHALL cover: while ARMED, write CONTROL=0 -> DMA_GO=0 the next cycle; a write of SRC while ARMED leaves SRC unchanged.
REQ-034 SHALL cover, with DMA_AHB_CSR_IRQ_EN and IE=1: DMA_DONE rising -> IRQ=1; a write-1 to STATUS[2] -> IRQ=0; reset asserted while ARMED -> DMA_GO=0 immediately.

Source files
------------

// File: rtl/dma_ahb_pkg.sv
// Shared register map, field positions and GO FSM encoding
// for the DMA AHB control/status block.
package dma_ahb_pkg;

   localparam logic [2:0] OFF_CONTROL = 3'd0;
   localparam logic [2:0] OFF_STATUS  = 3'd1;
   localparam logic [2:0] OFF_SRC     = 3'd2;
   localparam logic [2:0] OFF_DST     = 3'd3;
   localparam logic [2:0] OFF_BNUM    = 3'd4;
   localparam logic [2:0] OFF_BURST   = 3'd5;
   localparam logic [2:0] OFF_VERSION = 3'd7;

   localparam int B_EN   = 31;
   localparam int B_IE   = 30;
   localparam int B_GO   = 0;
   localparam int B_BUSY = 0;
   localparam int B_DONE = 1;
   localparam int B_IP   = 2;
   localparam int B_ERR  = 3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_RELEASE = 2'd2
   } go_state_e;

   function automatic logic burst_legal(input logic [4:0] b);
      return (b == 5'd1) || (b == 5'd4) ||
             (b == 5'd8) || (b == 5'd16);
   endfunction

endpackage

// File: rtl/dma_ahb_csr_if.sv
// AHB-lite slave bus bundle for the DMA control/status block.
interface dma_ahb_csr_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic [1:0]  HRESP;
   logic        HREADYout;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE,
      output HBURST, HWDATA, HREADY,
      input  HRDATA, HRESP, HREADYout
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE,
      input  HBURST, HWDATA, HREADY,
      output HRDATA, HRESP, HREADYout
   );
endinterface

// File: rtl/dma_ahb_csr.sv
// DMA AHB control/status registers with GO handshake FSM.
// Optional interrupt logic: define DMA_AHB_CSR_IRQ_EN.
module dma_ahb_csr
   import dma_ahb_pkg::*;
#(
   parameter logic [31:0] P_VERSION = 32'h2014_0429
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   dma_ahb_csr_if.slave  ahb,
   output logic          DMA_EN,
   output logic          DMA_GO,
   output logic [31:0]   DMA_SRC,
   output logic [31:0]   DMA_DST,
   output logic [15:0]   DMA_BNUM,
   output logic [4:0]    DMA_BURST,
   input  logic          DMA_BUSY,
   input  logic          DMA_DONE,
   output logic          IRQ
);

   logic        access;
   logic        wr_q, wr_d;
   logic [2:0]  waddr_q, waddr_d;
   logic [31:0] src_q, src_d;
   logic [31:0] dst_q, dst_d;
   logic [15:0] bnum_q, bnum_d;
   logic [4:0]  burst_q, burst_d;
   logic        en_q, en_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] rd_val;
   logic        ctrl_wr, stat_wr;
   logic        idle, go_req, legal;
   logic        ie_d, ip_d;
   go_state_e   state_q, state_d;

   assign access  = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
   assign wr_d    = access & ahb.HWRITE;
   assign waddr_d = ahb.HADDR[4:2];

   assign ctrl_wr = wr_q & (waddr_q == OFF_CONTROL);
   assign stat_wr = wr_q & (waddr_q == OFF_STATUS);
   assign idle    = (state_q == S_IDLE);
   assign go_req  = ctrl_wr & ahb.HWDATA[B_GO];
   assign legal   = (bnum_q != 16'd0) & burst_legal(burst_q);
   assign en_d    = ctrl_wr ? ahb.HWDATA[B_EN] : en_q;

   always_comb begin
      src_d   = src_q;
      dst_d   = dst_q;
      bnum_d  = bnum_q;
      burst_d = burst_q;
      if (wr_q && idle) begin
         unique case (waddr_q)
            OFF_SRC:   src_d   = ahb.HWDATA;
            OFF_DST:   dst_d   = ahb.HWDATA;
            OFF_BNUM:  bnum_d  = ahb.HWDATA[15:0];
            OFF_BURST: burst_d = ahb.HWDATA[4:0];
            default:   ;
         endcase
      end
   end

   always_comb begin
      err_d = err_q;
      if (idle && go_req && !legal)
         err_d = 1'b1;
      else if (stat_wr && ahb.HWDATA[B_ERR])
         err_d = 1'b0;
   end

`ifdef DMA_AHB_CSR_IRQ_EN
   logic ie_q, ip_q, done_q;

   assign ie_d = ctrl_wr ? ahb.HWDATA[B_IE] : ie_q;
   // A DONE edge beats a simultaneous write-1 clear
   assign ip_d = (DMA_DONE & ~done_q) |
                 (ip_q & ~(stat_wr & ahb.HWDATA[B_IP]));

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ie_q   <= 1'b0;
         ip_q   <= 1'b0;
         done_q <= 1'b0;
      end else begin
         ie_q   <= ie_d;
         ip_q   <= ip_d;
         done_q <= DMA_DONE;
      end
   end

   assign IRQ = ip_q & ie_q;
`else
   assign ie_d = 1'b0;
   assign ip_d = 1'b0;
   assign IRQ  = 1'b0;
`endif

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (ctrl_wr && !ahb.HWDATA[B_EN]) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE:
               if (go_req && legal) state_d = S_ARMED;
            S_ARMED:
               if (DMA_DONE) state_d = S_RELEASE;
            S_RELEASE:
               if (!DMA_DONE) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      DMA_GO = (state_q == S_ARMED);
   end

   // Reads see next-state values so a write in its data phase bypasses
   always_comb begin
      rd_val = '0;
      unique case (ahb.HADDR[4:2])
         OFF_CONTROL: begin
            rd_val[B_EN] = en_d;
            rd_val[B_IE] = ie_d;
            rd_val[B_GO] = (state_d == S_ARMED);
         end
         OFF_STATUS: begin
            rd_val[B_ERR]  = err_d;
            rd_val[B_IP]   = ip_d;
            rd_val[B_DONE] = DMA_DONE;
            rd_val[B_BUSY] = DMA_BUSY;
         end
         OFF_SRC:     rd_val = src_d;
         OFF_DST:     rd_val = dst_d;
         OFF_BNUM:    rd_val[15:0] = bnum_d;
         OFF_BURST:   rd_val[4:0] = burst_d;
         OFF_VERSION: rd_val = P_VERSION;
         default:     rd_val = '0;
      endcase
   end

   assign rdata_d = (access && !ahb.HWRITE) ? rd_val : '0;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_q    <= 1'b0;
         waddr_q <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         bnum_q  <= '0;
         burst_q <= '0;
         en_q    <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         wr_q    <= wr_d;
         waddr_q <= waddr_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         bnum_q  <= bnum_d;
         burst_q <= burst_d;
         en_q    <= en_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign ahb.HRDATA    = rdata_q;
   assign ahb.HRESP     = 2'b00;
   assign ahb.HREADYout = 1'b1;

   assign DMA_EN    = en_q;
   assign DMA_SRC   = src_q;
   assign DMA_DST   = dst_q;
   assign DMA_BNUM  = bnum_q;
   assign DMA_BURST = burst_q;

   logic unused_ok;
   assign unused_ok = ^{ahb.HADDR[31:5], ahb.HADDR[1:0],
                        ahb.HTRANS[0], ahb.HSIZE, ahb.HBURST};

endmodule
